// File: rtl/adder_ser_pkg.sv
// Shared types and helpers for the adder result serializer.
// ADDER_SER_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package adder_ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } ser_state_e;

    // Bits per serial frame: start + sum + carry (+ parity) + stop.
    function automatic int frame_bits(input int sum_w);
`ifdef ADDER_SER_PARITY_EN
        return sum_w + 4;
`else
        return sum_w + 3;
`endif
    endfunction

endpackage

// File: rtl/adder_sum_serializer_if.sv
// Valid/ready handshake carrying one adder result (sum word plus carry-out).
interface adder_sum_serializer_if #(
    parameter int SUM_W = 4
);
    logic [SUM_W-1:0] sum_in;
    logic             cout_in;
    logic             in_valid;
    logic             in_ready;

    modport master (output sum_in, output cout_in, output in_valid, input in_ready);
    modport slave  (input sum_in, input cout_in, input in_valid, output in_ready);
endinterface

// File: rtl/adder_ser_fifo.sv
// Synchronous FIFO with occupancy count; head word is readable combinationally
// so the serializer can pop and load its shift register on the same edge.
module adder_ser_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // Full blocks a write even when a read happens in the same cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/adder_sum_serializer.sv
// Buffers adder results and sends each as a UART-style frame (LSB first) on ser_out.
// Define ADDER_SER_PARITY_EN to append an even-parity bit before the stop bit.
module adder_sum_serializer
    import adder_ser_pkg::*;
#(
    parameter int SUM_W     = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_COUNT = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    adder_sum_serializer_if.slave       in_if,
    output logic                        ser_out,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      fifo_count
);
    localparam int W  = SUM_W + 1;
    localparam int DW = $clog2(MAX_COUNT);
    localparam int BW = $clog2(SUM_W + 1);

    logic [W-1:0] head;
    logic         fifo_full, fifo_empty, pop;

    ser_state_e   state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [W-1:0]  shift_q, shift_d;
    logic          ser_q, ser_d;
    logic          term;
`ifdef ADDER_SER_PARITY_EN
    logic          par_q, par_d;
`endif

    adder_ser_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_if.in_valid),
        .wr_data ({in_if.cout_in, in_if.sum_in}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_if.in_ready = !fifo_full;
    assign ser_out        = ser_q;
    assign busy           = (state_q != IDLE);
    assign term           = (div_q == DW'(MAX_COUNT - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ser_d   = ser_q;
        pop     = 1'b0;
`ifdef ADDER_SER_PARITY_EN
        par_d   = par_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        div_d   = '0;
                        bit_d   = '0;
                        ser_d   = 1'b0;
                        state_d = START;
`ifdef ADDER_SER_PARITY_EN
                        par_d   = ^head;
`endif
                    end
                end
                START: begin
                    if (term) begin
                        div_d   = '0;
                        ser_d   = shift_q[0];
                        state_d = DATA;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                DATA: begin
                    if (term) begin
                        div_d = '0;
                        if (bit_q == BW'(SUM_W)) begin
`ifdef ADDER_SER_PARITY_EN
                            ser_d   = par_q;
                            state_d = PARITY;
`else
                            ser_d   = 1'b1;
                            state_d = STOP;
`endif
                        end else begin
                            // Bit on the line is shift_q[0]; the next one is shift_q[1].
                            bit_d   = bit_q + 1'b1;
                            shift_d = shift_q >> 1;
                            ser_d   = shift_q[1];
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
`ifdef ADDER_SER_PARITY_EN
                PARITY: begin
                    if (term) begin
                        div_d   = '0;
                        ser_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (term) begin
                        div_d = '0;
                        if (!fifo_empty) begin
                            // Chain straight into the next frame with no idle bit.
                            pop     = 1'b1;
                            shift_d = head;
                            bit_d   = '0;
                            ser_d   = 1'b0;
                            state_d = START;
`ifdef ADDER_SER_PARITY_EN
                            par_d   = ^head;
`endif
                        end else begin
                            ser_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    ser_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ser_q   <= 1'b1;
`ifdef ADDER_SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ser_q   <= ser_d;
`ifdef ADDER_SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
